// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the main-memory arbiter.
// Burst length decode is kept here so the arbiter and any future users agree on it.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_e;

    typedef enum logic {
        OWN_DATA,
        OWN_FETCH
    } owner_e;

    localparam int unsigned BEAT_W = 5;

    function automatic logic [BEAT_W-1:0] beats(input logic [1:0] access_size);
        logic [BEAT_W-1:0] n;
        case (access_size)
            2'd0:    n = 5'd1;
            2'd1:    n = 5'd4;
            2'd2:    n = 5'd8;
            default: n = 5'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// Remaining-beat counter for an outstanding read burst.
// Loads on issue, counts down once per returned beat, flags the final beat.
module mem_arb_beat_cnt
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BEAT_W-1:0] load_beats,
    output logic              last
);

    logic [BEAT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_beats;
        end else if (count != '0) begin
            count <= count - 5'd1;
        end
    end

    assign last = (count == 5'd1);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between fetch (bursts) and the mem stage
// (single words), sequences read beats and routes returned data to the owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_rnw,
    input  logic [1:0]  d_store_size,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    input  logic [1:0]  f_access_size,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_stall,
    output logic        mem_enable,
    output logic [31:0] mem_addr,
    output logic        mem_rnw,
    output logic [1:0]  mem_access_size,
    output logic [1:0]  mem_store_size,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_state_e        state;
    owner_e            owner;
    logic [SW-1:0]     starve_cnt;
    logic              last_beat;
    logic              can_issue;
    logic              starve_sat;
    logic              fetch_sel;
    logic              accept;
    logic              issue_read;
    logic [BEAT_W-1:0] load_beats;

    assign starve_sat = (starve_cnt == SW'(STARVE_LIMIT));
    // Issue is only possible with nothing pending, or as the final beat returns.
    assign can_issue  = (state == IDLE) || ((state == BURST) && last_beat);
    assign fetch_sel  = f_req && (!d_req || starve_sat);
    assign accept     = can_issue && !mem_busy && (d_req || f_req) && !rst;

    assign d_gnt      = accept && !fetch_sel;
    assign f_gnt      = accept && fetch_sel;
    assign d_stall    = d_req && !d_gnt;
    assign f_stall    = f_req && !f_gnt;

    assign issue_read = f_gnt || (d_gnt && d_rnw);
    assign load_beats = f_gnt ? beats(f_access_size) : 5'd1;

    assign d_rdata    = mem_rdata;
    assign f_rdata    = mem_rdata;

    mem_arb_beat_cnt u_beat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (issue_read),
        .load_beats (load_beats),
        .last       (last_beat)
    );

    always_comb begin
        mem_enable      = 1'b0;
        mem_addr        = '0;
        mem_rnw         = 1'b0;
        mem_access_size = '0;
        mem_store_size  = '0;
        mem_wdata       = '0;
        if (d_gnt) begin
            mem_enable      = 1'b1;
            mem_addr        = d_addr;
            mem_rnw         = d_rnw;
            mem_store_size  = d_store_size;
            mem_wdata       = d_wdata;
        end else if (f_gnt) begin
            mem_enable      = 1'b1;
            mem_addr        = f_addr;
            mem_rnw         = 1'b1;
            mem_access_size = f_access_size;
        end
    end

    // rvalid flags are registered alongside state so they track (state==BURST & owner).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_DATA;
            d_rvalid <= 1'b0;
            f_rvalid <= 1'b0;
        end else if (issue_read) begin
            state    <= BURST;
            owner    <= f_gnt ? OWN_FETCH : OWN_DATA;
            d_rvalid <= d_gnt;
            f_rvalid <= f_gnt;
        end else if ((state == BURST) && last_beat) begin
            state    <= IDLE;
            d_rvalid <= 1'b0;
            f_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !f_req || f_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && !starve_sat) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural burst memory returning addr ^ 0xC0DE0000.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_rnw;
    logic [1:0]  d_store_size;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        f_req;
    logic [31:0] f_addr;
    logic [1:0]  f_access_size;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_stall;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic        mem_rnw;
    logic [1:0]  mem_access_size;
    logic [1:0]  mem_store_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_addr(d_addr), .d_rnw(d_rnw), .d_store_size(d_store_size),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_stall(d_stall),
        .f_req(f_req), .f_addr(f_addr), .f_access_size(f_access_size), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_stall(f_stall),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_rnw(mem_rnw),
        .mem_access_size(mem_access_size), .mem_store_size(mem_store_size),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    // Memory: beat k of a read accepted in cycle T appears in cycle T+1+k.
    logic [31:0] m_cur = '0;
    int          m_left = 0;
    always @(posedge clk) begin
        if (mem_enable && !mem_busy && mem_rnw) begin
            m_cur  <= mem_addr;
            m_left <= (mem_access_size == 2'd0) ? 1 : (mem_access_size == 2'd1) ? 4 :
                      (mem_access_size == 2'd2) ? 8 : 16;
        end else if (m_left > 0) begin
            m_cur  <= m_cur + 32'd4;
            m_left <= m_left - 1;
        end
    end
    assign mem_rdata = (m_left > 0) ? (m_cur ^ 32'hC0DE_0000) : 32'hDEAD_BEEF;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        d_req = 1'b0; d_addr = '0; d_rnw = 1'b1; d_store_size = 2'd0; d_wdata = '0;
        f_req = 1'b0; f_addr = '0; f_access_size = 2'd0; mem_busy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_idle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({d_gnt, f_gnt, d_rvalid, f_rvalid, mem_enable, d_stall, f_stall} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=0000000",
                     {d_gnt, f_gnt, d_rvalid, f_rvalid, mem_enable, d_stall, f_stall});
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_access_size !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_mem_fields addr=%h size=%0d want 0/0", mem_addr, mem_access_size);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single_load;
        d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h100;
        @(negedge clk);
        vectors++;
        if (d_gnt !== 1'b1 || d_stall !== 1'b0 || mem_enable !== 1'b1 || mem_addr !== 32'h100
            || mem_access_size !== 2'd0 || mem_rnw !== 1'b1) begin
            miscompares++;
            $display("FAIL load_grant gnt=%b stall=%b en=%b addr=%h size=%0d rnw=%b want 1 0 1 100 0 1",
                     d_gnt, d_stall, mem_enable, mem_addr, mem_access_size, mem_rnw);
        end
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE_0100 || f_rvalid !== 1'b0 || d_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL load_data rvalid=%b data=%h frv=%b stall=%b want 1 c0de0100 0 0",
                     d_rvalid, d_rdata, f_rvalid, d_stall);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (d_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_rvalid_drop got=%b want=0", d_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_fetch_burst;
        logic [31:0] exp_data;
        f_req = 1'b1; f_addr = 32'h2000; f_access_size = 2'd1;
        @(negedge clk);
        vectors++;
        if (f_gnt !== 1'b1 || mem_access_size !== 2'd1 || mem_store_size !== 2'd0 || f_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL burst4_grant gnt=%b size=%0d ssize=%0d stall=%b want 1 1 0 0",
                     f_gnt, mem_access_size, mem_store_size, f_stall);
        end
        next_cycle();
        f_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h300;
            end
            @(negedge clk);
            exp_data = 32'hC0DE_2000 + 32'(4 * k);
            vectors++;
            if (f_rvalid !== 1'b1 || f_rdata !== exp_data) begin
                miscompares++;
                $display("FAIL burst4_beat%0d rvalid=%b data=%h want 1 %h", k, f_rvalid, f_rdata, exp_data);
            end
            if (k >= 1) begin
                vectors++;
                if (d_gnt !== (k == 3) || d_stall !== (k != 3)) begin
                    miscompares++;
                    $display("FAIL burst4_dside%0d gnt=%b stall=%b want %b %b",
                             k, d_gnt, d_stall, k == 3, k != 3);
                end
            end
            next_cycle();
        end
        d_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (f_rvalid !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE_0300) begin
            miscompares++;
            $display("FAIL burst4_followon frv=%b drv=%b data=%h want 0 1 c0de0300",
                     f_rvalid, d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation;
        logic exp_f;
        d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h400;
        f_req = 1'b1; f_addr = 32'h800; f_access_size = 2'd0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_f = (c == 4) || (c == 9);
            vectors++;
            if (f_gnt !== exp_f || d_gnt !== !exp_f || f_stall !== !exp_f || d_stall !== exp_f) begin
                miscompares++;
                $display("FAIL starve_cycle%0d fgnt=%b dgnt=%b fstall=%b dstall=%b want %b %b %b %b",
                         c, f_gnt, d_gnt, f_stall, d_stall, exp_f, !exp_f, !exp_f, exp_f);
            end
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        vectors++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'hC0DE_0800) begin
            miscompares++;
            $display("FAIL starve_fetch_data rvalid=%b data=%h want 1 c0de0800", f_rvalid, f_rdata);
        end
        next_cycle();
    endtask

    task automatic test_store_then_burst;
        logic [31:0] exp_data;
        d_req = 1'b1; d_rnw = 1'b0; d_store_size = 2'd2; d_wdata = 32'hAB; d_addr = 32'h500;
        @(negedge clk);
        vectors++;
        if (d_gnt !== 1'b1 || mem_rnw !== 1'b0 || mem_store_size !== 2'd2 || mem_wdata !== 32'hAB
            || mem_access_size !== 2'd0 || mem_addr !== 32'h500) begin
            miscompares++;
            $display("FAIL store_fields gnt=%b rnw=%b ss=%0d wd=%h as=%0d addr=%h want 1 0 2 ab 0 500",
                     d_gnt, mem_rnw, mem_store_size, mem_wdata, mem_access_size, mem_addr);
        end
        next_cycle();
        drive_idle();
        f_req = 1'b1; f_addr = 32'h1000; f_access_size = 2'd3;
        @(negedge clk);
        vectors++;
        if (f_gnt !== 1'b1 || d_rvalid !== 1'b0 || mem_access_size !== 2'd3 || mem_store_size !== 2'd0) begin
            miscompares++;
            $display("FAIL burst16_grant gnt=%b drv=%b as=%0d ss=%0d want 1 0 3 0",
                     f_gnt, d_rvalid, mem_access_size, mem_store_size);
        end
        next_cycle();
        f_addr = 32'h1100; f_access_size = 2'd0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_data = 32'hC0DE_1000 + 32'(4 * k);
            vectors++;
            if (f_rvalid !== 1'b1 || f_rdata !== exp_data || f_gnt !== (k == 15)) begin
                miscompares++;
                $display("FAIL burst16_beat%0d rvalid=%b data=%h gnt=%b want 1 %h %b",
                         k, f_rvalid, f_rdata, f_gnt, exp_data, k == 15);
            end
            next_cycle();
        end
        f_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'hC0DE_1100) begin
            miscompares++;
            $display("FAIL burst16_next rvalid=%b data=%h want 1 c0de1100", f_rvalid, f_rdata);
        end
        next_cycle();
    endtask

    task automatic test_busy;
        d_req = 1'b1; d_rnw = 1'b1; d_addr = 32'h600;
        for (int c = 0; c < 4; c++) begin
            mem_busy = (c < 3);
            @(negedge clk);
            vectors++;
            if (d_gnt !== (c == 3) || d_stall !== (c != 3) || mem_enable !== (c == 3)) begin
                miscompares++;
                $display("FAIL busy_cycle%0d gnt=%b stall=%b en=%b want %b %b %b",
                         c, d_gnt, d_stall, mem_enable, c == 3, c != 3, c == 3);
            end
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        vectors++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE_0600) begin
            miscompares++;
            $display("FAIL busy_data rvalid=%b data=%h want 1 c0de0600", d_rvalid, d_rdata);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst;
        f_req = 1'b1; f_addr = 32'h3000; f_access_size = 2'd2;
        next_cycle();
        f_req = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        f_req = 1'b1; f_addr = 32'h3400; f_access_size = 2'd0;
        @(negedge clk);
        vectors++;
        if (f_rvalid !== 1'b0 || f_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_burst_regrant rvalid=%b gnt=%b want 0 1", f_rvalid, f_gnt);
        end
        next_cycle();
        f_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'hC0DE_3400) begin
            miscompares++;
            $display("FAIL rst_burst_newdata rvalid=%b data=%h want 1 c0de3400", f_rvalid, f_rdata);
        end
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_burst_quiet%0d frv=%b drv=%b want 0 0", c, f_rvalid, d_rvalid);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_fetch_burst();
        test_starvation();
        test_store_then_burst();
        test_busy();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
